// File: rtl/display_scan_controller.sv
// display_scan_controller
// Scans a four-digit multiplexed seven-segment display and selects which
// latched sensor-error message is shown. Pending errors are shown one at a time
// (lowest index first) and blink until the operator clears them.
//
// The prescaler and the 2-bit digit counter run continuously in every state.
// The error message FSM only changes state at frame_end, which is the last
// cycle of digit 3. msg_sel therefore never changes in the middle of a frame.
//
// digit_en_n and msg_valid are registered from the next-state values. They
// change on the same edge as the counter, so the enables stay aligned with
// saida1Contador/saida2Contador.
module display_scan_controller #(
    parameter int PRESCALE     = 4096,
    parameter int BLINK_FRAMES = 32,
    parameter int N_ERR        = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [N_ERR-1:0] err_in,
    input  logic             err_clear,
    output logic             saida1Contador,
    output logic             saida2Contador,
    output logic [3:0]       digit_en_n,
    output logic [1:0]       msg_sel,
    output logic             msg_valid,
    output logic [N_ERR-1:0] err_pending,
    output logic [1:0]       fsm_state
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FW = $clog2(BLINK_FRAMES) + 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHOW_ON  = 2'd1,
        ST_SHOW_OFF = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PW-1:0]    presc;
    logic [1:0]       cnt;
    logic [1:0]       cnt_nxt;
    logic [FW-1:0]    frame_cnt;
    logic [FW-1:0]    frame_nxt;
    logic [1:0]       sel_nxt;
    logic [1:0]       first_idx;
    logic [N_ERR-1:0] clr_mask;
    logic [N_ERR-1:0] pending_nxt;
    logic [3:0]       den_nxt;
    logic             valid_nxt;
    logic             tick;
    logic             frame_end;
    logic             any_pending;

    assign tick        = (presc == PRESC_LAST);
    assign frame_end   = tick && (cnt == 2'd3);
    assign cnt_nxt     = tick ? (cnt + 2'd1) : cnt;
    assign any_pending = |err_pending;

    assign saida1Contador = cnt[1];
    assign saida2Contador = cnt[0];
    assign fsm_state      = state;

    // Prescaler: counts 0..PRESCALE-1 and wraps. Each digit dwells one full period.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Digit counter: advances on tick and wraps from 3 to 0.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= 2'd0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Lowest-index pending error. Only indices below N_ERR can be produced.
    always_comb begin
        first_idx = 2'd0;
        for (int i = N_ERR - 1; i >= 0; i--) begin
            if (err_pending[i]) begin
                first_idx = 2'(i);
            end
        end
    end

    // Clear mask for the displayed error. A clear is ignored while nothing is shown.
    always_comb begin
        clr_mask = '0;
        if (err_clear && msg_valid) begin
            for (int i = 0; i < N_ERR; i++) begin
                if (msg_sel == 2'(i)) begin
                    clr_mask[i] = 1'b1;
                end
            end
        end
    end

    // The set is ORed in after the clear so that a simultaneous set wins.
    assign pending_nxt = (err_pending & ~clr_mask) | err_in;

    // Error latch register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err_pending <= '0;
        end else begin
            err_pending <= pending_nxt;
        end
    end

    // FSM state, frame counter and message select registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            frame_cnt <= '0;
            msg_sel   <= 2'd0;
        end else begin
            state     <= state_nxt;
            frame_cnt <= frame_nxt;
            msg_sel   <= sel_nxt;
        end
    end

    // Next-state logic. Decisions are taken only at frame_end. The frame
    // counter restarts whenever the state changes.
    always_comb begin
        state_nxt = state;
        frame_nxt = frame_cnt;
        sel_nxt   = msg_sel;
        if (frame_end) begin
            unique case (state)
                ST_IDLE: begin
                    if (any_pending) begin
                        state_nxt = ST_SHOW_ON;
                        frame_nxt = '0;
                        sel_nxt   = first_idx;
                    end
                end
                ST_SHOW_ON, ST_SHOW_OFF: begin
                    if (!any_pending) begin
                        state_nxt = ST_IDLE;
                        frame_nxt = '0;
                    end else begin
                        sel_nxt = first_idx;
                        if (frame_cnt == FRAME_LAST) begin
                            state_nxt = (state == ST_SHOW_ON) ? ST_SHOW_OFF : ST_SHOW_ON;
                            frame_nxt = '0;
                        end else begin
                            frame_nxt = frame_cnt + FW'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    frame_nxt = '0;
                end
            endcase
        end
    end

    // Display outputs are derived from the next state and the next counter value.
    always_comb begin
        den_nxt   = 4'b1111;
        valid_nxt = (state_nxt != ST_IDLE);
        if (state_nxt == ST_SHOW_ON) begin
            den_nxt = ~(4'b0001 << cnt_nxt);
        end
    end

    // Registered digit enables and the message-valid flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            digit_en_n <= 4'b1111;
            msg_valid  <= 1'b0;
        end else begin
            digit_en_n <= den_nxt;
            msg_valid  <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller with PRESCALE=4, BLINK_FRAMES=2, N_ERR=4.
// A cycle model pushes the expected outputs at every rising edge, and they are
// compared at the next falling edge. A table of hand-derived checkpoints and
// hand-written reset sequences run alongside the model.
module tb_display_scan_controller;

    localparam int P  = 4;
    localparam int BF = 2;
    localparam int NE = 4;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [NE-1:0] err_in = '0;
    logic          err_clear = 1'b0;
    logic          saida1Contador;
    logic          saida2Contador;
    logic [3:0]    digit_en_n;
    logic [1:0]    msg_sel;
    logic          msg_valid;
    logic [NE-1:0] err_pending;
    logic [1:0]    fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    display_scan_controller #(
        .PRESCALE(P),
        .BLINK_FRAMES(BF),
        .N_ERR(NE)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .err_in(err_in),
        .err_clear(err_clear),
        .saida1Contador(saida1Contador),
        .saida2Contador(saida2Contador),
        .digit_en_n(digit_en_n),
        .msg_sel(msg_sel),
        .msg_valid(msg_valid),
        .err_pending(err_pending),
        .fsm_state(fsm_state)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle model: {state, cnt, den, sel, valid, pend} = 15 bits
    logic [14:0] exp_q[$];
    int          m_k;
    logic [1:0]  m_state;
    int          m_frame;
    logic [1:0]  m_sel;
    logic        m_valid;
    logic [3:0]  m_den;
    logic [3:0]  m_pend;
    logic [1:0]  m_cnt;

    function automatic logic [1:0] lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    task automatic model_step();
        logic       fe;
        logic [3:0] np;
        if (!resetn) begin
            m_k = 0; m_state = 2'd0; m_frame = 0; m_sel = 2'd0;
            m_valid = 1'b0; m_den = 4'b1111; m_pend = 4'b0000; m_cnt = 2'd0;
            exp_q.delete();
        end else begin
            fe = ((m_k % (4 * P)) == (4 * P - 1));
            np = m_pend | err_in;
            if (err_clear && m_valid) np[m_sel] = err_in[m_sel];
            if (fe) begin
                if (m_pend == 4'b0000) begin
                    m_state = 2'd0;
                    m_frame = 0;
                end else begin
                    m_sel = lowest(m_pend);
                    if (m_state == 2'd0) begin
                        m_state = 2'd1;
                        m_frame = 0;
                    end else if (m_frame == BF - 1) begin
                        m_state = (m_state == 2'd1) ? 2'd2 : 2'd1;
                        m_frame = 0;
                    end else begin
                        m_frame = m_frame + 1;
                    end
                end
            end
            m_k     = m_k + 1;
            m_cnt   = 2'((m_k / P) % 4);
            m_den   = (m_state == 2'd1) ? ~(4'b0001 << m_cnt) : 4'b1111;
            m_valid = (m_state != 2'd0);
            m_pend  = np;
        end
        exp_q.push_back({m_state, m_cnt, m_den, m_sel, m_valid, m_pend});
    endtask

    // Model advance on every edge and on asynchronous reset
    always @(posedge clock or negedge resetn) model_step();

    // Scoreboard compare on the falling edge
    always @(negedge clock) begin
        logic [14:0] e;
        logic [14:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {fsm_state, saida1Contador, saida2Contador, digit_en_n, msg_sel, msg_valid, err_pending};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL scoreboard: got st=%0d cnt=%0d den=%b sel=%0d valid=%b pend=%b, expected st=%0d cnt=%0d den=%b sel=%0d valid=%b pend=%b (t=%0t)",
                         a[14:13], a[12:11], a[10:7], a[6:5], a[4], a[3:0],
                         e[14:13], e[12:11], e[10:7], e[6:5], e[4], e[3:0], $time);
            end
        end
    end

    typedef struct {
        logic [3:0] ein;
        logic       clr;
        int         n;
        logic [1:0] cnt;
        logic [3:0] den;
        logic [1:0] sel;
        logic       valid;
        logic [3:0] pend;
    } vec_t;

    vec_t vecs[19];

    // Drive inputs for one cycle, then idle for n-1 cycles; ends on a falling edge
    task automatic apply(input logic [3:0] ein, input logic clr, input int n);
        err_in    = ein;
        err_clear = clr;
        @(negedge clock);
        err_in    = '0;
        err_clear = 1'b0;
        repeat (n - 1) @(negedge clock);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cnt"},   {30'd0, saida1Contador, saida2Contador}, 32'd0);
        check({tag, "_den"},   {28'd0, digit_en_n}, 32'hF);
        check({tag, "_sel"},   {30'd0, msg_sel}, 32'd0);
        check({tag, "_valid"}, {31'd0, msg_valid}, 32'd0);
        check({tag, "_pend"},  {28'd0, err_pending}, 32'd0);
        check({tag, "_state"}, {30'd0, fsm_state}, 32'd0);
    endtask

    initial begin
        // Checkpoints, counted in rising edges since reset release (frame = 16 cycles)
        vecs[0]  = '{4'b0000, 1'b0, 48, 2'd0, 4'b1111, 2'd0, 1'b0, 4'b0000}; // idle 3 frames
        vecs[1]  = '{4'b0010, 1'b0,  6, 2'd1, 4'b1111, 2'd0, 1'b0, 4'b0010}; // latch mid-frame
        vecs[2]  = '{4'b0000, 1'b0, 10, 2'd0, 4'b1110, 2'd1, 1'b1, 4'b0010}; // shown at frame_end
        vecs[3]  = '{4'b0000, 1'b0,  4, 2'd1, 4'b1101, 2'd1, 1'b1, 4'b0010};
        vecs[4]  = '{4'b0000, 1'b0, 28, 2'd0, 4'b1111, 2'd1, 1'b1, 4'b0010}; // blink off
        vecs[5]  = '{4'b0000, 1'b0, 32, 2'd0, 4'b1110, 2'd1, 1'b1, 4'b0010}; // back on
        vecs[6]  = '{4'b0010, 1'b1,  1, 2'd0, 4'b1110, 2'd1, 1'b1, 4'b0010}; // set wins
        vecs[7]  = '{4'b0000, 1'b1,  2, 2'd0, 4'b1110, 2'd1, 1'b1, 4'b0000}; // clear bit 1
        vecs[8]  = '{4'b0101, 1'b0,  1, 2'd1, 4'b1101, 2'd1, 1'b1, 4'b0101}; // sel held mid-frame
        vecs[9]  = '{4'b0000, 1'b0, 12, 2'd0, 4'b1110, 2'd0, 1'b1, 4'b0101}; // reselect 0
        vecs[10] = '{4'b0000, 1'b1,  3, 2'd0, 4'b1110, 2'd0, 1'b1, 4'b0100}; // clear 0 mid-frame
        vecs[11] = '{4'b0000, 1'b0, 13, 2'd0, 4'b1111, 2'd2, 1'b1, 4'b0100}; // sel 2, blink off
        vecs[12] = '{4'b0000, 1'b1,  4, 2'd1, 4'b1111, 2'd2, 1'b1, 4'b0000}; // clear last
        vecs[13] = '{4'b0000, 1'b0, 12, 2'd0, 4'b1111, 2'd2, 1'b0, 4'b0000}; // back to idle
        vecs[14] = '{4'b0100, 1'b0,  2, 2'd0, 4'b1111, 2'd2, 1'b0, 4'b0100};
        vecs[15] = '{4'b0000, 1'b1,  2, 2'd1, 4'b1111, 2'd2, 1'b0, 4'b0100}; // clear ignored
        vecs[16] = '{4'b0000, 1'b0, 12, 2'd0, 4'b1110, 2'd2, 1'b1, 4'b0100};
        vecs[17] = '{4'b0000, 1'b1,  1, 2'd0, 4'b1110, 2'd2, 1'b1, 4'b0000};
        vecs[18] = '{4'b0000, 1'b0, 15, 2'd0, 4'b1111, 2'd2, 1'b0, 4'b0000};

        // Reset block
        resetn    = 1'b0;
        err_in    = '0;
        err_clear = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_values("por");
        resetn = 1'b1;

        for (int i = 0; i < 19; i++) begin
            apply(vecs[i].ein, vecs[i].clr, vecs[i].n);
            check($sformatf("v%0d_cnt", i),   {30'd0, saida1Contador, saida2Contador}, {30'd0, vecs[i].cnt});
            check($sformatf("v%0d_den", i),   {28'd0, digit_en_n}, {28'd0, vecs[i].den});
            check($sformatf("v%0d_sel", i),   {30'd0, msg_sel}, {30'd0, vecs[i].sel});
            check($sformatf("v%0d_valid", i), {31'd0, msg_valid}, {31'd0, vecs[i].valid});
            check($sformatf("v%0d_pend", i),  {28'd0, err_pending}, {28'd0, vecs[i].pend});
        end

        // Mid-scan asynchronous reset: cnt=1, sel=2, pend=0001 beforehand
        apply(4'b0001, 1'b0, 5);
        check("pre_rst_pend", {28'd0, err_pending}, 32'h1);
        #2 resetn = 1'b0;
        #1;
        check_reset_values("async");
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("post_rst_cnt%0d", i), {30'd0, saida1Contador, saida2Contador}, 32'(i % 4));
            repeat (4) @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
